// File: rtl/orion_arb_pkg.sv
// Shared types and helpers for the orion clocked-to-asynchronous arbiter.
// Holds the FSM state enum, a clog2 that never returns 0, and the round-robin selector.
package orion_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2
   } arb_state_t;

   // Upper bound on requester count accepted by rr_select.
   localparam int MAX_REQ = 32;

   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // First set bit of valid at or above ptr, wrapping modulo n; 0 when none are set.
   function automatic int rr_select(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
      int   idx;
      int   sel;
      logic found;
      sel   = 0;
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         idx = ptr + k;
         if (idx >= n) idx = idx - n;
         if (k < n && !found && valid[idx[4:0]]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/orion_sync_ff.sv
// Single-bit multi-flop synchronizer with an asynchronous reset to a chosen value.
module orion_sync_ff #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chain <= {SYNC_STAGES{RESET_VAL}};
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], d};
      end
   end

   assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/orion_sync_arb_tx.sv
// Round-robin arbiter feeding one 2-phase bundled-data channel from NUM_REQ valid/ready requesters.
// One word in flight at a time; the next grant waits for the synchronized ack phase to match out_req.
module orion_sync_arb_tx
   import orion_arb_pkg::*;
#(
   parameter int   NUM_REQ     = 4,
   parameter int   WIDTH       = 8,
   parameter int   SYNC_STAGES = 2,
   parameter logic PO_INIT     = 1'b0,
   localparam int  SRC_W       = safe_clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic                     out_req,
   input  logic                     out_ack,
   output logic [WIDTH-1:0]         out_data,
   output logic [SRC_W-1:0]         out_src,
   output logic                     busy,
   output logic                     ack_err
);

   arb_state_t       state;
   logic [SRC_W-1:0] rr_ptr;
   logic [SRC_W-1:0] grant;
   logic [SRC_W-1:0] next_ptr;
   logic             any_valid;
   logic             ack_s;
   logic             ack_prev;

   orion_sync_ff #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (PO_INIT)
   ) u_ack_sync (
      .clk   (clk),
      .reset (reset),
      .d     (out_ack),
      .q     (ack_s)
   );

   // Grant is only offered in IDLE and is forced off while reset is held.
   always_comb begin
      any_valid = |req_valid;
      grant     = SRC_W'(rr_select(MAX_REQ'(req_valid), int'(rr_ptr), NUM_REQ));
      next_ptr  = (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
      req_ready = '0;
      if (state == IDLE && any_valid && !reset) begin
         req_ready = NUM_REQ'(1) << grant;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         out_req  <= PO_INIT;
         out_data <= '0;
         out_src  <= '0;
         rr_ptr   <= '0;
         ack_err  <= 1'b0;
         ack_prev <= PO_INIT;
      end else begin
         ack_prev <= ack_s;
         // An ack edge is only legitimate while a word is outstanding.
         if (ack_s != ack_prev && state != WAIT) begin
            ack_err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (any_valid) begin
                  out_data <= req_data[int'(grant)*WIDTH +: WIDTH];
                  out_src  <= grant;
                  rr_ptr   <= next_ptr;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               out_req <= ~out_req;
               state   <= WAIT;
            end
            WAIT: begin
               if (ack_s == out_req) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_orion_sync_arb_tx.sv
// Self-checking bench for orion_sync_arb_tx: randomized requesters, a cycle-timed echo
// responder standing in for the co-reset decoupled register, and a transaction-level grant model.
module tb_orion_sync_arb_tx;

   localparam int   NREQ = 4;
   localparam int   W    = 8;
   localparam int   SYNC = 2;
   localparam logic PO   = 1'b1;

   logic                clk;
   logic                reset;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*W-1:0]   req_data;
   logic                out_req;
   logic                out_ack;
   logic [W-1:0]        out_data;
   logic [1:0]          out_src;
   logic                busy;
   logic                ack_err;

   orion_sync_arb_tx #(
      .NUM_REQ     (NREQ),
      .WIDTH       (W),
      .SYNC_STAGES (SYNC),
      .PO_INIT     (PO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .out_req   (out_req),
      .out_ack   (out_ack),
      .out_data  (out_data),
      .out_src   (out_src),
      .busy      (busy),
      .ack_err   (ack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state: cycle counter plus the arithmetic timeline of the word in flight.
   int          cyc;
   int          idle_at;
   int          ready_cyc;
   int          ack_at;
   int          m_ptr;
   int          exp_src;
   logic [W-1:0] exp_data;
   logic        exp_req;
   int          mode;
   logic [NREQ-1:0] fixed_valid;
   int          ack_delay_fix;
   logic        use_a5;
   int          obs_log[$];

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic resetDut;
      reset     = 1'b1;
      req_valid = '1;
      req_data  = '0;
      out_ack   = PO;
      #3;
      checkOutput("rst_out_req", out_req, PO);
      checkOutput("rst_ready", req_ready, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_ack_err", ack_err, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_out_src", out_src, 0);
      checkOutput("rst_ready_clk", req_ready, 0);
      req_valid = '0;
      reset     = 1'b0;
      cyc       = 0;
      idle_at   = 0;
      ready_cyc = -10;
      ack_at    = -1;
      m_ptr     = 0;
      exp_req   = PO;
   endtask

   // Compare the DUT against the model at a negedge.
   task automatic evaluate;
      int              g;
      logic [NREQ-1:0] exp_rdy;
      logic            old_req;
      for (int r = 0; r < NREQ; r++) if (req_ready[r]) obs_log.push_back(r);
      if (cyc >= idle_at) begin
         g = -1;
         for (int k = 0; k < NREQ; k++)
            if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
         exp_rdy = (g < 0) ? '0 : (NREQ'(1) << g);
         checkOutput("req_ready", req_ready, exp_rdy);
         checkOutput("busy_idle", busy, 0);
         if (g >= 0) begin
            exp_data  = req_data[g*W +: W];
            exp_src   = g;
            m_ptr     = (g + 1) % NREQ;
            ready_cyc = cyc;
            exp_req   = ~exp_req;
            ack_at    = cyc + 2 + ((ack_delay_fix >= 0) ? ack_delay_fix : int'($urandom_range(0, 3)));
            idle_at   = ack_at + SYNC + 1;
         end
      end else begin
         checkOutput("ready_while_busy", req_ready, 0);
         checkOutput("busy", busy, 1);
         if (cyc == ready_cyc + 1) begin
            old_req = ~exp_req;
            checkOutput("load_data", out_data, exp_data);
            checkOutput("load_src", out_src, exp_src);
            checkOutput("load_req_held", out_req, old_req);
         end
         if (cyc == ready_cyc + 2) checkOutput("req_toggle", out_req, exp_req);
      end
   endtask

   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         cyc++;
         #1;
         if (cyc == ack_at) begin
            checkOutput("rx_req_phase", out_req, exp_req);
            checkOutput("rx_data", out_data, exp_data);
            out_ack = exp_req;
         end
         case (mode)
            0:       req_valid = NREQ'($urandom);
            1:       req_valid = '1;
            default: req_valid = fixed_valid;
         endcase
         for (int r = 0; r < NREQ; r++) req_data[r*W +: W] = W'($urandom);
         if (use_a5) req_data[2*W +: W] = 8'hA5;
         @(negedge clk);
         evaluate();
      end
   endtask

   task automatic drain;
      mode        = 2;
      fixed_valid = '0;
      if (idle_at - cyc + 1 > 0) applyStimulus(idle_at - cyc + 1);
   endtask

   initial begin
      int mask;
      mode          = 2;
      fixed_valid   = '0;
      ack_delay_fix = -1;
      use_a5        = 1'b0;
      cyc           = 0;
      resetDut();
      applyStimulus(3);

      // Single word from requester 2 with a slow ack.
      ack_delay_fix = 5;
      use_a5        = 1'b1;
      fixed_valid   = 4'b0100;
      applyStimulus(1);
      use_a5        = 1'b0;
      drain();
      checkOutput("held_data", out_data, 8'hA5);
      checkOutput("held_src", out_src, 2);
      ack_delay_fix = -1;

      // Pointer now at 3: only requester 1 valid, then all valid should pick 2.
      fixed_valid = 4'b0010;
      applyStimulus(1);
      drain();
      obs_log.delete();
      fixed_valid = 4'b1111;
      applyStimulus(1);
      drain();
      checkOutput("skip_next_grant", (obs_log.size() > 0) ? obs_log[0] : -1, 2);

      // Round-robin with every requester valid from a fresh reset.
      resetDut();
      obs_log.delete();
      mode = 1;
      applyStimulus(60);
      drain();
      checkOutput("rr_count", (obs_log.size() >= 5) ? 1 : 0, 1);
      for (int k = 0; k < 5 && k < obs_log.size(); k++) checkOutput("rr_order", obs_log[k], k % NREQ);
      for (int i = 0; i + NREQ <= obs_log.size(); i++) begin
         mask = 0;
         for (int j = 0; j < NREQ; j++) mask |= (1 << obs_log[i+j]);
         checkOutput("rr_window", mask, 4'hF);
      end

      // Random traffic.
      mode = 0;
      applyStimulus(150);
      drain();
      checkOutput("no_err_normal", ack_err, 0);

      // Spurious ack while IDLE, then restore phase alignment.
      @(posedge clk); cyc++; #1;
      out_ack = ~out_ack;
      repeat (2) begin @(posedge clk); cyc++; end
      @(negedge clk);
      checkOutput("ack_err_early", ack_err, 0);
      @(posedge clk); cyc++;
      @(negedge clk);
      checkOutput("ack_err_set", ack_err, 1);
      checkOutput("busy_spurious", busy, 0);
      @(posedge clk); cyc++; #1;
      out_ack = ~out_ack;
      applyStimulus(SYNC + 3);
      mode = 0;
      applyStimulus(40);
      drain();
      checkOutput("ack_err_sticky", ack_err, 1);

      // Reset while waiting for ack.
      ack_delay_fix = 100;
      fixed_valid   = 4'b0001;
      applyStimulus(4);
      checkOutput("pre_reset_busy", busy, 1);
      #2;
      reset   = 1'b1;
      out_ack = PO;
      #1;
      checkOutput("async_rst_req", out_req, PO);
      checkOutput("async_rst_busy", busy, 0);
      checkOutput("async_rst_err", ack_err, 0);
      ack_delay_fix = -1;
      resetDut();
      mode = 0;
      applyStimulus(120);
      drain();
      checkOutput("final_no_err", ack_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/orion_sync_arb_tx.md
Name: orion_sync_arb_tx

Overview:
- Clocked round-robin arbiter that shares one outgoing 2-phase bundled-data channel between NUM_REQ synchronous valid/ready requesters.
- Sits at the clocked/asynchronous boundary and drives the in_req/in_data side of the first orion_decoup_reg in a click pipeline.
- Accepts one word at a time, toggles out_req once per word, and waits for the matching out_ack phase before granting again.
- out_src tags the word with its requester index for downstream routing.

Parameters:
- NUM_REQ, 4: number of synchronous requesters (>=1).
- WIDTH, 8: data width per word.
- SYNC_STAGES, 2: flops in the out_ack synchronizer (>=2).
- PO_INIT, 0: reset phase of out_req and of the synchronized ack. Must equal PI_INIT of the attached decoupled register.
- SRC_W, max(1,$clog2(NUM_REQ)): width of out_src (derived localparam).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_ready  out  NUM_REQ  per-requester accept, at most one bit set.
- req_data  in  NUM_REQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- out_req  out  1  2-phase request; one toggle per word.
- out_ack  in  1  2-phase acknowledge from the asynchronous domain; unsynchronized.
- out_data  out  WIDTH  bundled data, registered.
- out_src  out  SRC_W  index of the requester that owns out_data.
- busy  out  1  high when state != IDLE.
- ack_err  out  1  sticky protocol error flag.

Behaviour:
- Reset (async, active-high) values:
  - out_req = PO_INIT; ack synchronizer chain = PO_INIT.
  - out_data = 0, out_src = 0, rr_ptr = 0, ack_err = 0, state = IDLE.
  - req_ready = 0 while reset is asserted.
- States: IDLE, LOAD, WAIT.
- IDLE:
  - If any req_valid is high, grant = first i with req_valid[i], searching from rr_ptr upward with wrap-around.
  - req_ready[grant] = 1 combinationally in IDLE only. All other bits are 0.
  - At the clock edge: out_data <= req_data[grant], out_src <= grant, rr_ptr <= (grant+1) mod NUM_REQ, state -> LOAD.
  - If no req_valid is high, stay in IDLE with req_ready = 0.
- LOAD:
  - Toggle out_req, state -> WAIT.
  - out_data is guaranteed stable for one full cycle before the out_req edge; this is the bundled-data setup rule.
- WAIT:
  - ack_s is out_ack after SYNC_STAGES flops.
  - When ack_s == out_req, state -> IDLE.
  - out_data and out_src stay held from LOAD until the next IDLE accept.
- Latency:
  - Accept edge t; out_req toggles at edge t+1.
  - After out_ack toggles, ack_s matches SYNC_STAGES edges later; IDLE follows one edge after that.
  - Earliest next accept is one cycle after returning to IDLE. Back-to-back throughput is one word per (3 + SYNC_STAGES + async round-trip) cycles.
- Fairness: a requester held valid is granted within NUM_REQ accepts. NUM_REQ=1 degenerates to a pass-through and rr_ptr stays 0.
- req_valid may drop without being accepted; there is no commitment before req_ready.
- ack_err: set when ack_s changes value while the state is IDLE or LOAD. It is cleared only by reset and does not alter sequencing.
- Reset mid-WAIT: all state returns to reset values immediately. The downstream decoupled register must be reset in the same reset domain so that phases realign at PO_INIT/PI_INIT.
- No combinational path exists from out_ack to any output.

Decomposition:
- Package orion_arb_pkg:
  - state enum (IDLE, LOAD, WAIT).
  - safe_clog2 function returning at least 1.
  - round-robin priority-select function (valid vector, pointer -> index).
- Sub-module orion_sync_ff:
  - Parameters: SYNC_STAGES, RESET_VAL.
  - Single-bit synchronizer with async reset to RESET_VAL; instantiated once for out_ack.

Test Plan:
- Reset with PO_INIT=1 -> out_req=1, req_ready=0, busy=0, ack_err=0. Release reset with no valid -> state stays IDLE.
- Single word: req_valid=4'b0100, req_data[2]=8'hA5 -> req_ready=4'b0100 for one cycle; next cycle out_data=8'hA5, out_src=2; out_req toggles one cycle later. Bench toggles out_ack after 5 cycles -> busy drops SYNC_STAGES+1 edges after the ack toggle.
- Round-robin: all four valid continuously, ack model echoes -> grant order 0,1,2,3,0. No requester is granted twice in any window of 4 grants.
- Wrap and skip: rr_ptr=3, only req_valid[1] high -> grant=1, rr_ptr becomes 2.
- Spurious ack: toggle out_ack while IDLE -> ack_err=1 after SYNC_STAGES+1 edges, sequencing unaffected. ack_err stays 1 until reset.
- Reset during WAIT, before ack -> out_req returns to PO_INIT asynchronously and state=IDLE. A subsequent word completes normally against a co-reset orion_decoup_reg, whose out_data equals the sent word.
